// File: rtl/pwm_capture_pkg.sv
// Shared register map, bit positions and FSM encoding for the PWM capture block.
package pwm_capture_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_MEAS    = 8'h08;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h0C;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int STAT_VALID     = 0;
  localparam int STAT_OVF       = 1;
  localparam int STAT_TIMEOUT   = 2;
  localparam int STAT_LEVEL     = 3;
  localparam int STAT_STATE_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_capture_edge.sv
// Synchroniser for an asynchronous input plus a one-flop rising-edge detector.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_dly_q, sync_dly_d;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], async_i};
    sync_dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~sync_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input between consecutive rising edges;
// results, sticky flags and control live behind a small 32-bit register bus.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int WIDTH_CNT   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          pwm_i,
  output logic          irq_o
);

  localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;
  localparam logic [WIDTH_CNT-1:0] CNT_ONE = WIDTH_CNT'(1);
  localparam int HALF = DW / 2;

  logic sync, rise;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (pwm_i),
    .sync_o  (sync),
    .rise_o  (rise)
  );

  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic [WIDTH_CNT-1:0] timeout_q, timeout_d;
  logic [WIDTH_CNT-1:0] cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
  logic [WIDTH_CNT-1:0] meas_p_q, meas_p_d, meas_h_q, meas_h_d;
  logic                 valid_q, valid_d, ovf_q, ovf_d, to_q, to_d;
  logic                 irq_q, irq_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic                 clr;
  logic [DW-1:0]        status_w, meas_w;
  logic                 unused_wr_bits;

  assign unused_wr_bits = ^wr_data_i[DW-1:WIDTH_CNT];

  always_comb begin
    en_d      = en_q;
    timeout_d = timeout_q;
    state_d   = state_q;
    cnt_p_d   = cnt_p_q;
    cnt_h_d   = cnt_h_q;
    meas_p_d  = meas_p_q;
    meas_h_d  = meas_h_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    to_d      = to_q;
    irq_d     = 1'b0;
    clr       = 1'b0;

    if (wr_en_i && addr_i == AW'(ADDR_CTRL)) begin
      en_d = wr_data_i[CTRL_EN];
      clr  = wr_data_i[CTRL_CLR];
    end
    if (wr_en_i && addr_i == AW'(ADDR_TIMEOUT)) begin
      timeout_d = wr_data_i[WIDTH_CNT-1:0];
    end

    // The FSM follows the registered enable, so a write acts one cycle later.
    if (!en_q) begin
      state_d = ST_IDLE;
      cnt_p_d = '0;
      cnt_h_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_p_d = '0;
          cnt_h_d = '0;
        end
        ST_ARM: begin
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_p_d = CNT_ONE;
            cnt_h_d = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            meas_p_d = cnt_p_q;
            meas_h_d = cnt_h_q;
            valid_d  = 1'b1;
            irq_d    = 1'b1;
            cnt_p_d  = CNT_ONE;
            cnt_h_d  = CNT_ONE;
          end else if (timeout_q != '0 && cnt_p_q == timeout_q) begin
            to_d    = 1'b1;
            state_d = ST_ARM;
            cnt_p_d = '0;
            cnt_h_d = '0;
          end else begin
            if (cnt_p_q != CNT_MAX) cnt_p_d = cnt_p_q + CNT_ONE;
            if (cnt_h_q != CNT_MAX && sync) cnt_h_d = cnt_h_q + CNT_ONE;
            if (cnt_p_d == CNT_MAX || cnt_h_d == CNT_MAX) ovf_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Clear overrides any capture happening in the same cycle.
    if (clr) begin
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      to_d     = 1'b0;
      meas_p_d = '0;
      meas_h_d = '0;
      irq_d    = 1'b0;
      if (en_q) begin
        state_d = ST_ARM;
        cnt_p_d = '0;
        cnt_h_d = '0;
      end
    end
  end

  always_comb begin
    status_w                           = '0;
    status_w[STAT_VALID]               = valid_q;
    status_w[STAT_OVF]                 = ovf_q;
    status_w[STAT_TIMEOUT]             = to_q;
    status_w[STAT_LEVEL]               = sync;
    status_w[STAT_STATE_LSB +: 2]      = state_q;
    meas_w                             = '0;
    meas_w[HALF +: WIDTH_CNT]          = meas_p_q;
    meas_w[0 +: WIDTH_CNT]             = meas_h_q;

    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (addr_i == AW'(ADDR_CTRL))         rd_data_d = DW'(en_q);
      else if (addr_i == AW'(ADDR_STATUS))  rd_data_d = status_w;
      else if (addr_i == AW'(ADDR_MEAS))    rd_data_d = meas_w;
      else if (addr_i == AW'(ADDR_TIMEOUT)) rd_data_d = DW'(timeout_q);
      else                                  rd_data_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      timeout_q <= '0;
      cnt_p_q   <= '0;
      cnt_h_q   <= '0;
      meas_p_q  <= '0;
      meas_h_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
      cnt_p_q   <= cnt_p_d;
      cnt_h_q   <= cnt_h_d;
      meas_p_q  <= meas_p_d;
      meas_h_q  <= meas_h_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      to_q      <= to_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign irq_o     = irq_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: register table plus PWM measurement sequences.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  logic        clk;
  logic        rst_i;
  logic [7:0]  addr_i;
  logic [31:0] wr_data_i;
  logic        wr_en_i;
  logic        rd_en_i;
  logic [31:0] rd_data_o;
  logic        pwm_i;
  logic        irq_o;

  pwm_capture #(.AW(8), .DW(32), .WIDTH_CNT(16), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .wr_data_i (wr_data_i),
    .wr_en_i   (wr_en_i),
    .rd_en_i   (rd_en_i),
    .rd_data_o (rd_data_o),
    .pwm_i     (pwm_i),
    .irq_o     (irq_o)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int irq_cyc = 0;
  int pwm_per = 0;
  int pwm_hi = 0;
  int pwm_ph = 0;
  bit pwm_lvl = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PWM source: per>0 gives a periodic wave starting high at phase 0.
  initial begin
    pwm_i = 1'b0;
    forever begin
      @(negedge clk);
      if (pwm_per > 0) begin
        pwm_i  = (pwm_ph < pwm_hi);
        pwm_ph = (pwm_ph + 1 >= pwm_per) ? 0 : pwm_ph + 1;
      end else begin
        pwm_i = pwm_lvl;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (irq_o === 1'b1) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input bit rd, output logic [31:0] q);
    @(negedge clk);
    addr_i = a; wr_data_i = d; wr_en_i = wr; rd_en_i = rd;
    @(negedge clk);
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    q = rd_data_o;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_op(1'b1, a, d, 1'b0, dummy);
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] q);
    bus_op(1'b0, a, 32'h0, 1'b1, q);
  endtask

  task automatic wait_irq(input int target, input int budget, input string name);
    int k = 0;
    while (irq_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (irq_cnt < target) begin
      n_chk++;
      $display("FAIL %s: irq count %0d required %0d within %0d cycles", name, irq_cnt, target, budget);
    end
  endtask

  initial begin
    logic [31:0] q, st;
    int base, r_cyc, t_cyc;
    bit found;

    vecs[0]  = '{1'b0, ADDR_CTRL,    32'h0,         32'h0};
    vecs[1]  = '{1'b0, ADDR_STATUS,  32'h0,         32'h0};
    vecs[2]  = '{1'b0, ADDR_MEAS,    32'h0,         32'h0};
    vecs[3]  = '{1'b0, ADDR_TIMEOUT, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 8'h10,        32'h0,         32'h0};
    vecs[5]  = '{1'b1, ADDR_TIMEOUT, 32'h0000_1234, 32'h0};
    vecs[6]  = '{1'b0, ADDR_TIMEOUT, 32'h0,         32'h0000_1234};
    vecs[7]  = '{1'b1, ADDR_TIMEOUT, 32'hABCD_5678, 32'h0000_1234};
    vecs[8]  = '{1'b0, ADDR_TIMEOUT, 32'h0,         32'h0000_5678};
    vecs[9]  = '{1'b1, ADDR_STATUS,  32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b0, ADDR_STATUS,  32'h0,         32'h0};
    vecs[11] = '{1'b1, ADDR_MEAS,    32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, ADDR_MEAS,    32'h0,         32'h0};
    vecs[13] = '{1'b1, 8'h20,        32'hFFFF_FFFF, 32'h0};
    vecs[14] = '{1'b1, ADDR_CTRL,    32'h0000_0002, 32'h0};
    vecs[15] = '{1'b0, ADDR_CTRL,    32'h0,         32'h0};
    vecs[16] = '{1'b1, ADDR_TIMEOUT, 32'h0,         32'h0000_5678};
    vecs[17] = '{1'b0, ADDR_TIMEOUT, 32'h0,         32'h0};

    rst_i = 1'b1; addr_i = '0; wr_data_i = '0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_rdata", rd_data_o, 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, q);
      chk($sformatf("vec%0d", i), q, vecs[i].exp);
    end

    pwm_lvl = 1'b1;
    repeat (5) @(negedge clk);
    reg_rd(ADDR_STATUS, q);
    chk("status_level", q, 32'h08);
    pwm_lvl = 1'b0;
    repeat (5) @(negedge clk);

    // Enable and first measurement, 1000/250.
    reg_wr(ADDR_CTRL, 32'h1);
    reg_rd(ADDR_CTRL, q);
    chk("ctrl_en", q, 32'h1);
    reg_rd(ADDR_STATUS, q);
    chk("status_arm", q, 32'h10);
    pwm_hi = 250; pwm_ph = 0; pwm_per = 1000;
    wait_irq(1, 3000, "first_capture");
    repeat (500) @(negedge clk);
    chk("irq_single", irq_cnt, 1);
    reg_rd(ADDR_MEAS, q);
    chk("meas_1000_250", q, 32'h03E8_00FA);
    reg_rd(ADDR_STATUS, q);
    chk("status_valid", q, 32'h21);

    // Duty change mid-run; the first captures afterwards may be mixed.
    pwm_hi = 750;
    wait_irq(irq_cnt + 3, 4000, "duty_change");
    reg_rd(ADDR_MEAS, q);
    chk("meas_1000_750", q, 32'h03E8_02EE);

    // Timeout: stop the input right after a capture.
    reg_wr(ADDR_TIMEOUT, 32'd2000);
    wait_irq(irq_cnt + 1, 1500, "pre_timeout");
    pwm_per = 0; pwm_lvl = 1'b0;
    r_cyc = irq_cyc;
    base = irq_cnt;
    @(negedge clk);
    addr_i = ADDR_STATUS; rd_en_i = 1'b1;
    found = 1'b0; t_cyc = 0; st = '0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(posedge clk);
      #1;
      if (rd_data_o[STAT_TIMEOUT]) begin
        found = 1'b1; t_cyc = cyc; st = rd_data_o;
      end
    end
    @(negedge clk);
    rd_en_i = 1'b0;
    chk("timeout_seen", 32'(found), 32'h1);
    chk("timeout_latency", 32'(t_cyc - r_cyc), 32'd2001);
    chk("timeout_status", st, 32'h15);
    reg_rd(ADDR_MEAS, q);
    chk("timeout_meas_kept", q, 32'h03E8_02EE);
    chk("timeout_no_irq", irq_cnt, base);

    // Resume with a 400/100 waveform.
    pwm_hi = 100; pwm_ph = 0; pwm_per = 400;
    wait_irq(irq_cnt + 2, 1500, "resume");
    reg_rd(ADDR_MEAS, q);
    chk("meas_400_100", q, 32'h0190_0064);
    reg_rd(ADDR_STATUS, q);
    chk("status_resume", q, 32'h2D);

    // Overflow: period longer than the counter range.
    reg_wr(ADDR_TIMEOUT, 32'h0);
    pwm_per = 0; pwm_lvl = 1'b0;
    repeat (6) @(negedge clk);
    reg_wr(ADDR_CTRL, 32'h3);
    reg_rd(ADDR_STATUS, q);
    chk("clr_status", q, 32'h10);
    reg_rd(ADDR_MEAS, q);
    chk("clr_meas", q, 32'h0);
    pwm_hi = 100; pwm_ph = 0; pwm_per = 65600;
    wait_irq(irq_cnt + 1, 70000, "overflow");
    reg_rd(ADDR_MEAS, q);
    chk("meas_ovf", q, 32'hFFFF_0064);
    reg_rd(ADDR_STATUS, q);
    chk("status_ovf", q, 32'h2B);

    // clr written on the exact cycle of a capture (captures 40 cycles apart).
    pwm_hi = 10; pwm_ph = 0; pwm_per = 40;
    wait_irq(irq_cnt + 2, 300, "clr_sync");
    repeat (38) @(negedge clk);
    base = irq_cnt;
    reg_wr(ADDR_CTRL, 32'h3);
    reg_rd(ADDR_STATUS, q);
    chk("clr_cap_status", q, 32'h18);
    reg_rd(ADDR_MEAS, q);
    chk("clr_cap_meas", q, 32'h0);
    chk("clr_cap_no_irq", irq_cnt, base);

    // Reset in the middle of MEASURE.
    wait_irq(irq_cnt + 1, 200, "pre_reset");
    pwm_per = 0; pwm_lvl = 1'b0;
    repeat (6) @(negedge clk);
    reg_rd(ADDR_STATUS, q);
    chk("status_measure", q, 32'h21);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_rst_irq", 32'(irq_o), 32'h0);
    chk("mid_rst_rdata", rd_data_o, 32'h0);
    reg_rd(ADDR_STATUS, q);
    chk("mid_rst_status", q, 32'h0);
    reg_rd(ADDR_MEAS, q);
    chk("mid_rst_meas", q, 32'h0);
    reg_rd(ADDR_CTRL, q);
    chk("mid_rst_ctrl", q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures a PWM waveform, such as the output of the team's PWM generator, and reports period and high time through the same 8-bit-address / 32-bit-data register bus as the generator. It sits directly downstream of the generator, closing the loop so software or a bench can check programmed period/duty against the produced waveform. It synchronises the input and detects edges. A small FSM counts clock cycles between consecutive rising edges and the high cycles within them, then latches results with sticky status flags.

## Interface
- AW, 8: register address width
- DW, 32: register data width
- WIDTH_CNT, 16: period/high counter width (≤ DW/2)
- SYNC_STAGES, 2: input synchroniser depth (≥ 2)

- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- addr_i  in  AW  register address (byte address, word-aligned)
- wr_data_i  in  DW  write data
- wr_en_i  in  1  write strobe, one cycle per write
- rd_en_i  in  1  read strobe, one cycle per read
- rd_data_o  out  DW  registered read data
- pwm_i  in  1  PWM input (asynchronous)
- irq_o  out  1  one-cycle pulse on each new measurement

## Operation
- Registers:
  - 0x00 CTRL RW: [0] en (reset 0); [1] clr, write-1 pulse, reads 0.
  - 0x04 STATUS RO: [0] valid, [1] ovf (sticky), [2] timeout (sticky), [3] synced input level, [5:4] FSM state.
  - 0x08 MEAS RO: [31:16] period, [15:0] high.
  - 0x0C TIMEOUT RW: [WIDTH_CNT-1:0], reset 0; 0 disables timeout.
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored.
- pwm_i passes through SYNC_STAGES flops, then one edge-detect flop. rise = sync & ~sync_d.
- FSM states: IDLE=0, ARM=1, MEASURE=2.
  - IDLE: while en=0, counters held at 0. Setting en=1 moves to ARM.
  - ARM: on rise, cnt_p←1, cnt_h←1, go to MEASURE.
  - MEASURE, no rise: cnt_p+=1, cnt_h+=sync. Both counters saturate at all-ones. Reaching saturation sets ovf.
  - MEASURE, rise: MEAS←{cnt_p, cnt_h}, valid←1, irq_o pulses, cnt_p←1, cnt_h←1, stay in MEASURE.
  - MEASURE, TIMEOUT≠0 and cnt_p==TIMEOUT with no rise: timeout←1, go to ARM, MEAS unchanged. This covers 0 %/100 % duty inputs (no edges).
  - en←0 from any state: go to IDLE next cycle. MEAS and flags are retained.
- Result semantics: rising edges P cycles apart with H synced-high cycles give MEAS={P,H}.
- clr: clears valid, ovf, timeout and MEAS. If en=1, go to ARM.
- Simultaneous events:
  - clr and capture in the same cycle: clr wins, no irq_o.
  - rise and timeout compare in the same cycle: rise wins.
  - Read and write in the same cycle: both execute; read returns the pre-write value.

## Timing
- Reset values: rd_data_o=0, irq_o=0; all registers, flags, counters and the synchroniser are 0; FSM in IDLE.
- Reset mid-measurement aborts it fully. No partial result is latched.
- Input latency: a pwm_i rising edge is seen as rise SYNC_STAGES+1 cycles later. Capture and irq_o occur on that cycle. MEAS/valid are readable from the next cycle.
- Read latency 1: rd_data_o updates on the clock edge after rd_en_i is sampled and holds until the next read.
- Write effect is visible the cycle after wr_en_i. en=1 takes effect (IDLE→ARM) one cycle after the write.
- Minimum measurable pulse: 1 cycle high/low after synchronisation. Narrower glitches may be missed.

## Structure
- Package pwm_capture_pkg holds:
  - register offsets (ADDR_CTRL/STATUS/MEAS/TIMEOUT)
  - CTRL/STATUS bit positions
  - FSM state encoding (IDLE/ARM/MEASURE, 2 bits)
- One sub-module, sync_edge_det: SYNC_STAGES-deep synchroniser plus rising-edge detector. Outputs sync level and rise.
- Top holds the FSM, counters and register file.

## Test plan
- Reset, then read all four registers → all 0, irq_o=0, STATUS[5:4]=IDLE.
- en=1; pwm_i period 1000 cycles, high 250 → after second rise, irq_o pulses once; MEAS=0x03E8_00FA, valid=1.
- Change to 1000/750 mid-run → the first period after the change may be mixed; the following capture gives MEAS=0x03E8_02EE.
- TIMEOUT=2000, pwm_i held at 0 after one rise → timeout=1 at cnt_p=2000, state ARM, MEAS unchanged. A later 400-cycle waveform resumes captures.
- WIDTH_CNT=16, pwm_i period 70000 → ovf=1, MEAS period=0xFFFF.
- clr written on the same cycle as a capture → valid=0, MEAS=0, no irq_o. Reset asserted mid-MEASURE → all outputs 0 the next cycle.
